serial_tx_shift: RTL and testbench
==================================

// Module: serial_tx_shift
// PURPOSE
//   Parallel-to-serial transmitter: loads a WIDTH-bit word and shifts it out LSB first, one bit per clk.
//   Each bit carries a valid strobe so a gated-D-latch receiver (en = sout_valid, d = sout) captures it.
//   Sits between a parallel data source and a latch-based serial receiver chain.
// PARAMETERS
//   WIDTH  8  data word width in bits (legal range >= 2)
// PORTS
//   clk         in   1      rising-edge clock; the single clock domain
//   rst         in   1      synchronous reset, active-high
//   load        in   1      request to send din; accepted only when ready=1
//   din         in   WIDTH  parallel data; sampled on the accepting edge
//   ready       out  1      1 = idle, load will be accepted
//   sout        out  1      serial data bit, LSB first
//   sout_valid  out  1      1 = sout holds a valid bit this cycle (receiver latch enable)
//   done        out  1      one-cycle pulse after the last bit
// BEHAVIOUR
//   - Reset: the only reset is synchronous and active-high. On any edge with rst=1, state<=IDLE,
//     ready=1, sout=0, sout_valid=0, done=0, and the shift register and bit counter clear.
//     rst overrides all other inputs, including mid-word; the partial word is abandoned.
//   - All outputs are registered. No combinational path from input to output.
//   - FSM states: IDLE, SHIFT, PAR (only with the macro), DONE.
//   - IDLE: ready=1, sout_valid=0, done=0, sout=0.
//     On an edge with load=1: shreg<=din, cnt<=0, sout<=din[0], sout_valid<=1, ready<=0, ->SHIFT.
//   - SHIFT: bit i of din is on sout during the i-th cycle after the accepting edge (i=0..WIDTH-1).
//     Each edge shifts shreg right and increments cnt.
//     - When cnt==WIDTH-1, the next state is PAR if the macro is defined, otherwise DONE.
//   - PAR: sout = parity bit, sout_valid=1, for one cycle; then ->DONE.
//   - DONE: sout_valid=0, sout=0, done=1, ready=0, for one cycle; then ->IDLE, with ready=1 on the next cycle.
//   - Load rules:
//     - load while ready=0 is ignored. It is not queued, and din changes do not affect the word in flight.
//     - Minimum spacing between load accepts is WIDTH+2 cycles without the macro, WIDTH+3 with it.
//   - cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1 and never wraps.
//   - load and rst asserted on the same edge: rst wins, and the word is not accepted.
// CONFIGURATION
//   SERIAL_TX_PARITY_EN defined:
//     - After the data bits, one extra valid cycle carries an even-parity bit (^din as sampled).
//     - The total ones count across data+parity is even.
//   SERIAL_TX_PARITY_EN undefined:
//     - There is no PAR state. DONE follows the last data bit directly.
//     - Exactly WIDTH valid cycles are sent per word.
// TESTING (WIDTH=8)
//   1. rst=1 for 2 edges, then released.
//      -> ready=1, sout=0, sout_valid=0, done=0.
//   2. load=1, din=8'hA5, from idle.
//      -> sout = 1,0,1,0,0,1,0,1 on cycles 0..7 with sout_valid=1.
//      -> With the macro: cycle 8 sout=0 (parity) with valid=1.
//      -> done=1 on the following cycle, then ready=1.
//   3. din=8'h01, macro defined.
//      -> The parity cycle has sout=1.
//      -> Without the macro, done pulses right after cycle 7.
//   4. load=1 with din=8'hFF at cycle 3 of a word started with 8'h0F.
//      -> The load is ignored, and the serial stream stays 1,1,1,1,0,0,0,0.
//   5. rst=1 at cycle 4 of a word.
//      -> Next edge: sout_valid=0, ready=1, done never pulses.
//      -> A fresh load of 8'h3C then sends 0,0,1,1,1,1,0,0 cleanly.
//   6. Back-to-back: load held at 1 continuously with din=8'h81.
//      -> Words are accepted exactly every WIDTH+2 (no macro) or WIDTH+3 (macro) cycles.
//      -> Each word is 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/serial_tx_shift.sv
// Parallel-to-serial transmitter: shifts a WIDTH-bit word out LSB first with a per-bit valid strobe.
// Optional macro SERIAL_TX_PARITY_EN appends one even-parity bit after the data bits.
module serial_tx_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        PAR   = 2'd3
    } state_t;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t             state_r;
    state_t             state_nx_s;
    logic [WIDTH-1:0]   shreg_r;
    logic [WIDTH-1:0]   shreg_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic               sout_nx_s;
    logic               valid_nx_s;
    logic               done_nx_s;
    logic               ready_nx_s;
`ifdef SERIAL_TX_PARITY_EN
    logic               par_r;
    logic               par_nx_s;
`endif

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nx_s = state_r;
        shreg_nx_s = shreg_r;
        cnt_nx_s   = cnt_r;
        sout_nx_s  = 1'b0;
        valid_nx_s = 1'b0;
        done_nx_s  = 1'b0;
        ready_nx_s = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_nx_s   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (load) begin
                    // Bit 0 goes straight to sout; shreg keeps only the bits still to send.
                    shreg_nx_s = {1'b0, din[WIDTH-1:1]};
                    cnt_nx_s   = '0;
                    sout_nx_s  = din[0];
                    valid_nx_s = 1'b1;
                    state_nx_s = SHIFT;
`ifdef SERIAL_TX_PARITY_EN
                    par_nx_s   = even_parity(din);
`endif
                end else begin
                    ready_nx_s = 1'b1;
                end
            end
            SHIFT: begin
                shreg_nx_s = {1'b0, shreg_r[WIDTH-1:1]};
                if (cnt_r == CNT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                    sout_nx_s  = par_r;
                    valid_nx_s = 1'b1;
                    state_nx_s = PAR;
`else
                    done_nx_s  = 1'b1;
                    state_nx_s = DONE;
`endif
                end else begin
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                    sout_nx_s  = shreg_r[0];
                    valid_nx_s = 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
                done_nx_s  = 1'b1;
                state_nx_s = DONE;
            end
`endif
            DONE: begin
                ready_nx_s = 1'b1;
                state_nx_s = IDLE;
            end
            default: begin
                ready_nx_s = 1'b1;
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            cnt_r      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_r      <= 1'b0;
`endif
        end else begin
            state_r    <= state_nx_s;
            shreg_r    <= shreg_nx_s;
            cnt_r      <= cnt_nx_s;
            sout       <= sout_nx_s;
            sout_valid <= valid_nx_s;
            done       <= done_nx_s;
            ready      <= ready_nx_s;
`ifdef SERIAL_TX_PARITY_EN
            par_r      <= par_nx_s;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx_shift.sv
// Directed vector bench for serial_tx_shift (WIDTH=8); honours SERIAL_TX_PARITY_EN if defined.
module tb_serial_tx_shift;

    localparam int WIDTH = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int SPACING = WIDTH + 3;
`else
    localparam int SPACING = WIDTH + 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    serial_tx_shift #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             rst;
        logic             load;
        logic [WIDTH-1:0] din;
        logic             ready;
        logic             sout;
        logic             valid;
        logic             done;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input string nm, input logic r, input logic l, input logic [WIDTH-1:0] d,
                       input logic e_rdy, input logic e_s, input logic e_v, input logic e_d);
        vec_t v;
        v.name = nm; v.rst = r; v.load = l; v.din = d;
        v.ready = e_rdy; v.sout = e_s; v.valid = e_v; v.done = e_d;
        vecs.push_back(v);
    endtask

    // bits[i] is the expected sout on cycle i; busy_load/busy_din drive load/din while the word is in flight.
    task automatic add_word(input string nm, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] bits,
                            input logic par, input logic busy_load, input logic [WIDTH-1:0] busy_din);
        add(nm, 1'b0, 1'b1, d, 1'b0, bits[0], 1'b1, 1'b0);
        for (int i = 1; i < WIDTH; i++)
            add(nm, 1'b0, busy_load, busy_din, 1'b0, bits[i], 1'b1, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        add({nm, "_par"}, 1'b0, busy_load, busy_din, 1'b0, par, 1'b1, 1'b0);
`else
        if (par === 1'bx) $display("note: unexpected parity argument");
`endif
        add({nm, "_done"}, 1'b0, busy_load, busy_din, 1'b0, 1'b0, 1'b0, 1'b1);
        add({nm, "_idle"}, 1'b0, busy_load, busy_din, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int   rises;
        int   last_rise;
        logic prev_v;

        add("rst", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add("rst", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add("idle", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add_word("a5", 8'hA5, 8'b1010_0101, 1'b0, 1'b0, 8'h00);
        add_word("x01", 8'h01, 8'b0000_0001, 1'b1, 1'b0, 8'h00);
        add_word("ign", 8'h0F, 8'b0000_1111, 1'b0, 1'b1, 8'hFF);
        add("idle", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        // Word abandoned by reset after cycle 3; no done pulse may follow.
        add("part", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++)
            add("part", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        add("midrst", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SPACING; i++)
            add("postrst", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add("rstld", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        add("rstld_idle", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add_word("x3c", 8'h3C, 8'b0011_1100, 1'b0, 1'b0, 8'h00);
        for (int w = 0; w < 3; w++)
            add_word("b2b", 8'h81, 8'b1000_0001, 1'b0, 1'b1, 8'h81);

        foreach (vecs[k]) begin
            rst  = vecs[k].rst;
            load = vecs[k].load;
            din  = vecs[k].din;
            @(posedge clk);
            #1;
            n_vec++;
            if ({ready, sout, sout_valid, done} !== {vecs[k].ready, vecs[k].sout, vecs[k].valid, vecs[k].done}) begin
                n_fail++;
                $display("FAIL %s vec %0d: ready/sout/valid/done got %b%b%b%b want %b%b%b%b", vecs[k].name, k,
                         ready, sout, sout_valid, done,
                         vecs[k].ready, vecs[k].sout, vecs[k].valid, vecs[k].done);
            end
        end

        // Continuous load: accepts must be exactly SPACING cycles apart.
        rst       = 1'b0;
        load      = 1'b1;
        din       = 8'h81;
        rises     = 0;
        last_rise = 0;
        prev_v    = sout_valid;
        for (int c = 0; c <= 4 * SPACING; c++) begin
            @(posedge clk);
            #1;
            if (sout_valid && !prev_v) begin
                if (rises > 0) begin
                    n_vec++;
                    if (c - last_rise != SPACING) begin
                        n_fail++;
                        $display("FAIL spacing: got %0d cycles want %0d", c - last_rise, SPACING);
                    end
                end
                rises++;
                last_rise = c;
            end
            prev_v = sout_valid;
        end
        n_vec++;
        if (rises != 5) begin
            n_fail++;
            $display("FAIL accept_count: got %0d want 5", rises);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
